xorshift_rng: RTL and testbench

XORSHIFT_RNG -- requirements
Module: xorshift_rng

---
 rtl/xorshift_rng.sv | 86 ++++++++
 tb/tb_xorshift_rng.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/xorshift_rng.sv
// xorshift_rng: 64-bit xorshift generator that rejection-samples values into [start,last] under an AND-mask.
module xorshift_rng #(
    parameter logic [63:0] SEED_DEFAULT = 64'h1,
    parameter int          MAX_ITER     = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        seed_valid,
    input  logic [63:0] seed,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_start,
    input  logic [31:0] req_last,
    input  logic [31:0] req_mask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_timeout
);
    typedef enum logic [1:0] {IDLE, GEN, RESP} state_t;
    localparam logic [15:0] LAST_TRY = 16'(MAX_ITER - 1);
    state_t      r_state;
    logic [63:0] r_x;
    logic [15:0] r_cnt;
    logic [31:0] r_start, r_last, r_mask, r_data;
    logic        r_timeout;
    logic [63:0] w_x1, w_x2, w_x3;
    logic [31:0] w_val;
    logic        w_hit, w_last_try;
    assign w_x1       = r_x ^ (r_x << 13);
    assign w_x2       = w_x1 ^ (w_x1 >> 7);
    assign w_x3       = w_x2 ^ (w_x2 << 17);
    assign w_val      = w_x3[31:0] & r_mask;
    assign w_hit      = (w_val >= r_start) && (w_val <= r_last);
    assign w_last_try = r_cnt == LAST_TRY;
    assign req_ready   = r_state == IDLE;
    assign rsp_valid   = r_state == RESP;
    assign rsp_data    = r_data;
    assign rsp_timeout = r_timeout;
    // r_cnt holds the number of rejected attempts so far in the current request
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_x       <= SEED_DEFAULT;
            r_cnt     <= '0;
            r_start   <= '0;
            r_last    <= '0;
            r_mask    <= '0;
            r_data    <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (seed_valid)
                        r_x <= (seed == '0) ? SEED_DEFAULT : seed;
                    if (req_valid) begin
                        r_start <= req_start;
                        r_last  <= req_last;
                        r_mask  <= req_mask;
                        r_cnt   <= '0;
                        r_state <= GEN;
                    end
                end
                GEN: begin
                    r_x <= w_x3;
                    if (w_hit) begin
                        r_data    <= w_val;
                        r_timeout <= 1'b0;
                        r_state   <= RESP;
                    end else if (w_last_try) begin
                        r_data    <= '0;
                        r_timeout <= 1'b1;
                        r_state   <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_xorshift_rng.sv
// tb_xorshift_rng: directed requests with a response scoreboard and a golden xorshift rejection model.
module tb_xorshift_rng;
    localparam int MAX_ITER = 16;
    logic        clk = 0, reset = 1, seed_valid = 0, req_valid = 0, rsp_ready = 1;
    logic [63:0] seed = '0;
    logic [31:0] req_start = '0, req_last = '0, req_mask = '0;
    logic        req_ready, rsp_valid, rsp_timeout;
    logic [31:0] rsp_data;

    xorshift_rng #(.SEED_DEFAULT(64'h1), .MAX_ITER(MAX_ITER)) dut (
        .clk(clk), .reset(reset), .seed_valid(seed_valid), .seed(seed),
        .req_valid(req_valid), .req_ready(req_ready), .req_start(req_start),
        .req_last(req_last), .req_mask(req_mask), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        bit          t;
        int          k;
    } exp_t;
    exp_t q[$];
    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    logic [63:0] mx = 64'h1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endfunction

    function automatic logic [63:0] step(input logic [63:0] x);
        logic [63:0] a, b;
        a = x ^ (x << 13);
        b = a ^ (a >> 7);
        return b ^ (b << 17);
    endfunction

    task automatic model(input logic [31:0] s, l, m, output logic [31:0] d, output bit t, output int k);
        logic [31:0] v;
        d = '0;
        t = 1;
        k = MAX_ITER;
        for (int i = 1; i <= MAX_ITER; i++) begin
            mx = step(mx);
            v = mx[31:0] & m;
            if (v >= s && v <= l) begin
                d = v;
                t = 0;
                k = i;
                return;
            end
        end
    endtask

    // monitor: latency on rsp_valid rise, stability while stalled, payload at handshake
    int          acc = 0;
    bit          prev_v = 0;
    logic [31:0] held_d;
    logic        held_t;
    exp_t        me;
    always @(negedge clk) begin
        if (reset) begin
            prev_v = 0;
        end else begin
            if (req_valid && req_ready) acc = cyc + 1;
            if (rsp_valid && !prev_v) begin
                if (q.size() == 0) check("unexpected_rsp", 1, 0);
                else check("latency", cyc - acc, q[0].k);
                held_d = rsp_data;
                held_t = rsp_timeout;
            end else if (rsp_valid) begin
                check("stable_data", rsp_data, held_d);
                check("stable_timeout", rsp_timeout, held_t);
            end
            if (rsp_valid && rsp_ready && q.size() > 0) begin
                me = q.pop_front();
                check("rsp_data", rsp_data, me.d);
                check("rsp_timeout", rsp_timeout, me.t);
            end
            prev_v = rsp_valid;
        end
    end

    task automatic do_req(input logic [31:0] s, l, m, input bit sv, input logic [63:0] sd,
                          input int stall, input bit use_hand, input logic [31:0] hd,
                          input bit ht, input int hk);
        exp_t e;
        logic [31:0] md;
        bit mt;
        int mk, i;
        @(posedge clk); #1;
        if (sv) mx = (sd == '0) ? 64'h1 : sd;
        model(s, l, m, md, mt, mk);
        e.d = use_hand ? hd : md;
        e.t = use_hand ? ht : mt;
        e.k = use_hand ? hk : mk;
        q.push_back(e);
        req_start = s; req_last = l; req_mask = m;
        req_valid = 1; seed_valid = sv; seed = sd;
        rsp_ready = (stall == 0);
        @(posedge clk); #1;
        req_valid = 0; seed_valid = 0;
        i = 0;
        while (!rsp_valid && i < 100) begin
            @(posedge clk); #1;
            i++;
        end
        if (!rsp_valid) begin
            check("rsp_wait", 0, 1);
            q.delete();
            rsp_ready = 1;
            return;
        end
        for (int j = 0; j < stall; j++) begin
            seed_valid = (j == 4);
            seed = 64'h1234;
            @(posedge clk); #1;
        end
        seed_valid = 0;
        rsp_ready = 1;
        @(posedge clk); #1;
        check("ready_after_rsp", req_ready, 1);
        check("valid_after_rsp", rsp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit saw;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        reset = 0;
        @(posedge clk); #1;
        check("ready_after_rst", req_ready, 1);
        mx = 64'h1;
        do_req(32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 64'h0, 0, 1, 32'h40822041, 0, 1);
        @(posedge clk); #1;
        seed_valid = 1; seed = 64'h0;
        @(posedge clk); #1;
        seed_valid = 0;
        mx = 64'h1;
        do_req(32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 64'h0, 0, 1, 32'h40822041, 0, 1);
        do_req(32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 64'h1, 0, 1, 32'h40822041, 0, 1);
        do_req(32'd2, 32'd15, 32'hF, 1, 64'h1, 0, 0, 32'h0, 0, 0);
        do_req(32'd5, 32'd4, 32'hFFFFFFFF, 0, 64'h0, 0, 1, 32'h0, 1, 16);
        do_req(32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 64'h0, 0, 0, 32'h0, 0, 0);
        do_req(32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 64'h0, 10, 0, 32'h0, 0, 0);
        do_req(32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 64'h0, 0, 0, 32'h0, 0, 0);
        @(posedge clk); #1;
        req_start = 32'd5; req_last = 32'd4; req_mask = 32'hFFFFFFFF; req_valid = 1;
        @(posedge clk); #1;
        req_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        check("gen_no_valid", rsp_valid, 0);
        check("gen_not_ready", req_ready, 0);
        reset = 1; req_valid = 1; seed_valid = 1; seed = 64'h99;
        @(posedge clk); #1;
        reset = 0; req_valid = 0; seed_valid = 0;
        mx = 64'h1;
        check("abort_ready", req_ready, 1);
        check("abort_valid", rsp_valid, 0);
        check("abort_data", rsp_data, 0);
        check("abort_timeout", rsp_timeout, 0);
        saw = 0;
        for (int j = 0; j < 20; j++) begin
            @(posedge clk); #1;
            if (rsp_valid) saw = 1;
        end
        check("no_rsp_after_abort", saw, 0);
        do_req(32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 64'h0, 0, 1, 32'h40822041, 0, 1);
        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
